i2s_dac_transmitter: RTL
========================

// Module: i2s_dac_transmitter
// PURPOSE
//  Final audio stage, downstream of the reverb filter. Accepts one signed 16-bit L/R frame
//  per audio period through a one-entry valid/ready buffer. Generates BCLK/LRCK from CLK and
//  serialises the frame MSB-first to the codec DAC in standard I2S format (1-BCLK data delay).
//  Underruns repeat the last frame and are counted.
// PARAMETERS
//  BCLK_DIV   16  CLK cycles per BCLK half-period (>=2); frame = 4*SLOT_BITS*BCLK_DIV CLK
//  SLOT_BITS  32  BCLK periods per channel slot (>=DATA_BITS+1)
//  DATA_BITS  16  sample width; slot bits after the data are driven 0
// PORTS
//  CLK             in   1   system clock, all logic on posedge
//  RESET_N         in   1   asynchronous active-low reset
//  SAMPLE_L        in   16  signed left sample
//  SAMPLE_R        in   16  signed right sample
//  SAMPLE_VALID    in   1   L/R pair offered
//  SAMPLE_READY    out  1   holding buffer empty; accept on VALID&&READY
//  MUTE            in   1   force zero frame at next frame load
//  SAMPLE_REQ      out  1   1-CLK pulse on each frame load (upstream may advance)
//  UNDERRUN_COUNT  out  8   saturating count of frames loaded with buffer empty
//  AUD_BCLK        out  1   I2S bit clock
//  AUD_DACLRCK     out  1   0 = left slot, 1 = right slot
//  AUD_DACDAT      out  1   serial data, changes on BCLK falling edge
// BEHAVIOUR
//  Reset (async, any time): BCLK=0, LRCK=0, DACDAT=0, READY=1, REQ=0, UNDERRUN_COUNT=0,
//   div/bit counters=0, holding buffer empty, frame regs=0. All outputs are registered.
//   Reset mid-frame truncates the frame; the first frame after release starts at bit_cnt=0.
//  Clocking: div_cnt counts 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps and BCLK toggles.
//   On each BCLK 1->0 toggle (falling edge), bit_cnt advances 0..2*SLOT_BITS-1 (wrap).
//  LRCK=0 while bit_cnt<SLOT_BITS, else 1; updated on the falling edge with bit_cnt.
//  Data: at bit_cnt=n, DACDAT = slot bit (n mod SLOT_BITS)-1, MSB first.
//   Left MSB appears at bit_cnt=1, right MSB at SLOT_BITS+1.
//   Bit positions >=DATA_BITS, and position -1 (bit_cnt 0 / SLOT_BITS), output 0.
//  Frame load: in the CLK cycle where bit_cnt wraps to 0:
//   - buffer full: frame regs <= buffer (zeros if MUTE=1), buffer emptied, READY=1 next cycle.
//   - buffer empty: frame regs keep the previous frame (zeros if MUTE=1);
//     UNDERRUN_COUNT+1, saturating at 255.
//   - SAMPLE_REQ=1 for exactly this cycle.
//  Handshake: VALID&&READY captures L/R into the buffer; READY=0 from the next cycle.
//   VALID while READY=0 is ignored (no overwrite).
//  Simultaneous accept and load with buffer empty: the load is an underrun. The accepted
//   pair stays in the buffer for the next frame (no bypass).
//  Values pass bit-exact: no scaling or saturation; two's complement is sent as-is.
// TESTING
//  1 Reset: RESET_N low mid-frame -> all outputs at reset values within 1 CLK, asynchronously;
//    after release, first BCLK rise at CLK 16 (BCLK_DIV=16).
//  2 Single frame (BCLK_DIV=2): L=16'h8001, R=16'h7FFE accepted before the first load ->
//    DACDAT L slot = 0,1000000000000001,0x15; R slot = 0,0111111111111110,0x15; LRCK edges at bit_cnt 0/32.
//  3 Handshake: VALID held for 3 frames with new data each REQ -> every frame transmitted once;
//    READY low from accept until the next load; UNDERRUN_COUNT=0.
//  4 Underrun: no VALID for 300 frames -> last frame repeats; UNDERRUN_COUNT saturates at 255.
//  5 Collision: VALID asserted in the load cycle with buffer empty -> counter +1;
//    the pair is sent on the following frame.
//  6 MUTE: MUTE=1 at load with L=16'h1234 buffered -> all-zero frame, buffer consumed, READY=1.

Source files
------------

// File: rtl/i2s_dac_transmitter_if.sv
// Sample hand-off and codec-side signals of the I2S DAC transmitter.
// master = upstream audio source / bench, slave = the transmitter itself.
interface i2s_dac_transmitter_if #(
  parameter int DATA_BITS = 16
);
  logic signed [DATA_BITS-1:0] SAMPLE_L;
  logic signed [DATA_BITS-1:0] SAMPLE_R;
  logic                        SAMPLE_VALID;
  logic                        SAMPLE_READY;
  logic                        MUTE;
  logic                        SAMPLE_REQ;
  logic [7:0]                  UNDERRUN_COUNT;
  logic                        AUD_BCLK;
  logic                        AUD_DACLRCK;
  logic                        AUD_DACDAT;

  modport master (
    output SAMPLE_L, SAMPLE_R, SAMPLE_VALID, MUTE,
    input  SAMPLE_READY, SAMPLE_REQ, UNDERRUN_COUNT,
    input  AUD_BCLK, AUD_DACLRCK, AUD_DACDAT
  );

  modport slave (
    input  SAMPLE_L, SAMPLE_R, SAMPLE_VALID, MUTE,
    output SAMPLE_READY, SAMPLE_REQ, UNDERRUN_COUNT,
    output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT
  );
endinterface

// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: one-entry L/R holding buffer, BCLK/LRCK generation
// from CLK, and MSB-first serialisation with the standard 1-BCLK data delay.
// A frame load with no buffered pair repeats the previous frame and bumps a
// saturating underrun counter.
module i2s_dac_transmitter #(
  parameter int BCLK_DIV  = 16,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  i2s_dac_transmitter_if.slave bus
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_N    = BW'(SLOT_BITS);

  logic [DW-1:0] div_cnt;
  logic          bclk;
  logic [BW-1:0] bit_cnt;
  logic          lrck;
  logic          dacdat;
  logic          ready;
  logic          req;
  logic [7:0]    urun_cnt;

  logic signed [DATA_BITS-1:0] buf_l;
  logic signed [DATA_BITS-1:0] buf_r;
  logic signed [DATA_BITS-1:0] frm_l;
  logic signed [DATA_BITS-1:0] frm_r;

  logic          div_wrap;
  logic          bclk_fall;
  logic          frame_wrap;
  logic          accept;
  logic [BW-1:0] bit_nxt;

  // Serial bit for frame position n: slot position 0 is the I2S delay bit,
  // positions 1..DATA_BITS carry the sample MSB first, the rest pad with 0.
  function automatic logic slot_bit(input logic [BW-1:0] n,
                                    input logic signed [DATA_BITS-1:0] l,
                                    input logic signed [DATA_BITS-1:0] r);
    logic [BW-1:0]        p;
    logic [DATA_BITS-1:0] sel;
    logic [DATA_BITS-1:0] sh;
    p   = (n >= SLOT_N) ? (n - SLOT_N) : n;
    sel = (n >= SLOT_N) ? r : l;
    if ((p == '0) || (int'(p) > DATA_BITS)) begin
      return 1'b0;
    end
    sh = sel >> (DATA_BITS - int'(p));
    return sh[0];
  endfunction

  // Divider/bit-counter decode and handshake accept.
  always_comb begin
    div_wrap   = (div_cnt == DIV_LAST);
    bclk_fall  = div_wrap && bclk;
    frame_wrap = bclk_fall && (bit_cnt == BIT_LAST);
    bit_nxt    = frame_wrap ? '0 : (bit_cnt + 1'b1);
    accept     = bus.SAMPLE_VALID && ready;
  end

  // BCLK generation: toggle every BCLK_DIV CLK cycles.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit position, LRCK and serial data all advance on the BCLK falling edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt <= '0;
      lrck    <= 1'b0;
      dacdat  <= 1'b0;
    end else if (bclk_fall) begin
      bit_cnt <= bit_nxt;
      lrck    <= (bit_nxt >= SLOT_N);
      dacdat  <= slot_bit(bit_nxt, frm_l, frm_r);
    end
  end

  // Holding-buffer occupancy: READY drops on accept, returns when a load drains it.
  // Accept needs an empty buffer and a draining load needs a full one, so the two never coincide.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready <= 1'b1;
    end else if (accept) begin
      ready <= 1'b0;
    end else if (frame_wrap && !ready) begin
      ready <= 1'b1;
    end
  end

  // Holding-buffer data; only meaningful while READY is low.
  always_ff @(posedge CLK) begin
    if (accept) begin
      buf_l <= bus.SAMPLE_L;
      buf_r <= bus.SAMPLE_R;
    end
  end

  // Frame load at the wrap; an empty buffer repeats the previous frame, MUTE forces zeros.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frm_l <= '0;
      frm_r <= '0;
    end else if (frame_wrap) begin
      if (bus.MUTE) begin
        frm_l <= '0;
        frm_r <= '0;
      end else if (!ready) begin
        frm_l <= buf_l;
        frm_r <= buf_r;
      end
    end
  end

  // Load strobe and saturating underrun count (a same-cycle accept still counts as underrun).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req      <= 1'b0;
      urun_cnt <= 8'd0;
    end else begin
      req <= frame_wrap;
      if (frame_wrap && ready && (urun_cnt != 8'hFF)) begin
        urun_cnt <= urun_cnt + 8'd1;
      end
    end
  end

  assign bus.SAMPLE_READY   = ready;
  assign bus.SAMPLE_REQ     = req;
  assign bus.UNDERRUN_COUNT = urun_cnt;
  assign bus.AUD_BCLK       = bclk;
  assign bus.AUD_DACLRCK    = lrck;
  assign bus.AUD_DACDAT     = dacdat;

endmodule
